muldiv_unit: RTL and testbench

- Iterative RV32M execution unit that computes mul/mulh/mulhsu/mulhu/div/divu/rem/remu with a start/done handshake.
- Sits beside the single-cycle ALU in EX. The decoder routes funct7=0000001 ops here and stalls the pipeline while busy is high.
- Successor to the 4-bit ALU control scheme:
  - Replaces the three fixed mult/div/rem codes with the full funct3-indexed M-op set.
  - Parametrised in XLEN.
  - Multicycle, with flush support.

---
 rtl/muldiv_pkg.sv | 36 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op-class helpers for muldiv_unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_div(op_e op);
        return op[2];
    endfunction

    // mul is treated as signed: its low half is identical either way
    function automatic logic is_signed_a(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with start/done handshake and flush.
// Optional MULDIV_FAST_MUL_EN: multiplies bypass CALC via a single-cycle product in FIX.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned DW    = 2 * XLEN;

    state_e           state_q, state_d;
    op_e              op_in;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  mag_b_q;
    logic [DW-1:0]    acc_q;
    logic             sign_a_q, sign_b_q;

    logic             accept, div_zero, div_ovf, fast_mul;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum, div_trial, div_diff;
    logic [DW-1:0]    acc_step, prod, prod_s;
    logic [XLEN-1:0]  quot_s, rem_s, fix_val;

    // Operand decode and special-case detection for the start cycle
    always_comb begin
        op_in    = op_e'(op);
        accept   = (state_q == S_IDLE) && start && !flush;
        div_zero = is_div(op_in) && (b == '0);
        div_ovf  = is_div(op_in) && is_signed_a(op_in) &&
                   (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
        mag_a    = (is_signed_a(op_in) && a[XLEN-1]) ? -a : a;
        mag_b    = (is_signed_b(op_in) && b[XLEN-1]) ? -b : b;
`ifdef MULDIV_FAST_MUL_EN
        fast_mul = !is_div(op_in);
`else
        fast_mul = 1'b0;
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, mag_b_q} : '0);
        div_trial = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, mag_b_q};
        if (is_div(op_q)) begin
            acc_step = {(div_diff[XLEN] ? div_trial[XLEN-1:0] : div_diff[XLEN-1:0]),
                        acc_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and half/quotient/remainder selection
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod = DW'(acc_q[XLEN-1:0]) * DW'(mag_b_q);
`else
        prod = acc_q;
`endif
        prod_s = (sign_a_q ^ sign_b_q) ? -prod : prod;
        quot_s = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_s  = sign_a_q ? -acc_q[DW-1:XLEN] : acc_q[DW-1:XLEN];
        unique case (op_q)
            OP_MUL:                         fix_val = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fix_val = prod_s[DW-1:XLEN];
            OP_DIV, OP_DIVU:                fix_val = quot_s;
            OP_REM, OP_REMU:                fix_val = rem_s;
            default:                        fix_val = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (div_zero || div_ovf || fast_mul) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d == S_IDLE);
            busy    <= (state_d != S_IDLE);
            done    <= (state_d == S_DONE);
        end
    end

    // Datapath registers; bypassed divides preload the final quotient/remainder
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            mag_b_q  <= '0;
            acc_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            result   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= op_in;
                        cnt_q <= CNT_W'(XLEN);
                        if (div_zero) begin
                            acc_q    <= {a, {XLEN{1'b1}}};
                            mag_b_q  <= '0;
                            sign_a_q <= 1'b0;
                            sign_b_q <= 1'b0;
                        end else if (div_ovf) begin
                            acc_q    <= {{XLEN{1'b0}}, a};
                            mag_b_q  <= '0;
                            sign_a_q <= 1'b0;
                            sign_b_q <= 1'b0;
                        end else begin
                            acc_q    <= {{XLEN{1'b0}}, mag_a};
                            mag_b_q  <= mag_b;
                            sign_a_q <= is_signed_a(op_in) && a[XLEN-1];
                            sign_b_q <= is_signed_b(op_in) && b[XLEN-1];
                        end
                    end
                end
                S_CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        result <= fix_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops vs a
// 64-bit arithmetic reference model, flush/reset/ignored-start scenarios.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            flush;
    logic            ready, busy, done;
    logic [XLEN-1:0] result;

    int compared   = 0;
    int mismatched = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sx, sy, p;
        logic [63:0]     up;
        logic [31:0]     r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        r  = '0;
        case (o)
            3'd0: begin p = sx * sy; r = p[31:0]; end
            3'd1: begin p = sx * sy; up = p; r = up[63:32]; end
            3'd2: begin p = sx * longint'({32'b0, y}); up = p; r = up[63:32]; end
            3'd3: begin up = {32'b0, x} * {32'b0, y}; r = up[63:32]; end
            3'd4: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = x;
                else begin p = sx / sy; r = p[31:0]; end
            end
            3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) r = x;
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h0;
                else begin p = sx % sy; r = p[31:0]; end
            end
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        if (o[2] && y == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
`ifdef MULDIV_FAST_MUL_EN
        if (!o[2]) return 2;
`endif
        return XLEN + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from an idle cycle, check result, latency and one-cycle done
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          n;
        logic [31:0] exp_r;
        int          exp_l;
        exp_r = ref_model(o, x, y);
        exp_l = exp_latency(o, x, y);
        compared++;
        if (ready !== 1'b1) begin
            mismatched++;
            $display("FAIL %s ready-before-start: got %b want 1", name, ready);
        end
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
        n = 1;
        while (done !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        compared++;
        if (n != exp_l) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", name, n, exp_l);
        end
        compared++;
        if (result !== exp_r) begin
            mismatched++;
            $display("FAIL %s result: op=%0d a=%h b=%h got %h want %h", name, o, x, y, result, exp_r);
        end
        tick();
        compared++;
        if (done !== 1'b0 || ready !== 1'b1 || result !== exp_r) begin
            mismatched++;
            $display("FAIL %s after-done: done=%b ready=%b result=%h want done=0 ready=1 result=%h",
                     name, done, ready, result, exp_r);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        tick();
        tick();
        rst = 1'b0;
        compared++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            mismatched++;
            $display("FAIL reset: ready=%b busy=%b done=%b result=%h want 1 0 0 0", ready, busy, done, result);
        end
    endtask

    task automatic test_directed();
        run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD);
        run_op("mulh_min",    3'd1, 32'h8000_0000,  32'h8000_0000);
        run_op("mulhu_min",   3'd3, 32'h8000_0000,  32'h8000_0000);
        run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF,  32'd2);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2);
        run_op("div_by0",     3'd4, 32'h1234_5678,  32'd0);
        run_op("rem_by0",     3'd6, 32'h1234_5678,  32'd0);
        run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
        run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF);
    endtask

    task automatic pick_operands(output logic [2:0] o, output logic [31:0] x, output logic [31:0] y);
        int k;
        o = 3'($urandom);
        x = $urandom;
        y = $urandom;
        k = $urandom_range(0, 7);
        if (k == 0) y = '0;
        else if (k == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        else if (k == 2) begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
        else if (k == 3) y = -($urandom_range(1, 9));
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            pick_operands(o, x, y);
            run_op("random", o, x, y);
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] x, y;
        for (int i = 0; i < 20; i++) begin
            pick_operands(o, x, y);
            run_op("b2b", o, x, y);
        end
    endtask

    // Flush an in-flight divu at cycle t+at; no done, result untouched
    task automatic test_flush(input int at);
        logic [31:0] prev;
        int          pulses;
        prev = result;
        start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd13;
        tick();
        start = 1'b0;
        for (int n = 1; n < at; n++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        compared++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_at_%0d state: ready=%b busy=%b done=%b want 1 0 0", at, ready, busy, done);
        end
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        compared++;
        if (pulses != 0 || result !== prev) begin
            mismatched++;
            $display("FAIL flush_at_%0d quiet: pulses=%0d result=%h want 0 pulses result=%h", at, pulses, result, prev);
        end
    endtask

    task automatic test_start_flush_idle();
        int pulses;
        start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
        tick();
        start = 1'b0; flush = 1'b0;
        compared++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL start_flush_idle: ready=%b busy=%b want 1 0", ready, busy);
        end
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1) pulses++;
            tick();
        end
        compared++;
        if (pulses != 0) begin
            mismatched++;
            $display("FAIL start_flush_idle pulses: got %0d want 0", pulses);
        end
    endtask

    // A start at t+20 while busy must not disturb the running op or queue another
    task automatic test_ignored_start();
        int          n, pulses;
        logic [31:0] exp_r;
        exp_r = ref_model(3'd5, 32'hFFFF_0000, 32'd9);
        start = 1'b1; op = 3'd5; a = 32'hFFFF_0000; b = 32'd9;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 80) begin
            if (n == 20) begin start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; end
            else start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        compared++;
        if (n != XLEN + 2 || result !== exp_r) begin
            mismatched++;
            $display("FAIL ignored_start: latency=%0d result=%h want %0d %h", n, result, XLEN + 2, exp_r);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        compared++;
        if (pulses != 0 || result !== exp_r) begin
            mismatched++;
            $display("FAIL ignored_start queued: pulses=%0d result=%h want 0 %h", pulses, result, exp_r);
        end
    endtask

    task automatic test_rst_mid();
        start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        for (int n = 1; n < 5; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        compared++;
        if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
            mismatched++;
            $display("FAIL rst_mid: ready=%b busy=%b done=%b result=%h want 1 0 0 0", ready, busy, done, result);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush(10);
        test_flush(XLEN + 1);
        test_start_flush_idle();
        test_ignored_start();
        test_rst_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
